// File: rtl/therm_pkg.sv
// Shared types and helpers for the thermometer encoder and decoder blocks.
// Holds the FSM state encodings, the level-to-thermometer expansion and the W/K width check.
package therm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    // Widest thermometer the helpers support (K up to 8).
    localparam int THERM_MAX_W = 256;

    function automatic logic [THERM_MAX_W-1:0] therm_expand(input int unsigned lvl);
        logic [THERM_MAX_W-1:0] code;
        code = '0;
        for (int i = 0; i < THERM_MAX_W; i++) begin
            code[i] = (i < lvl);
        end
        return code;
    endfunction

    function automatic bit therm_width_ok(input int k, input int w);
        return (k >= 1) && (k <= 8) && (w == (1 << k) - 1);
    endfunction

endpackage

// File: rtl/therm_step_timer.sv
// Modulo-STEP_DIV step counter; tick is high on the last count of each period.
// clear restarts the period at zero, enable lets the counter advance.
module therm_step_timer #(
    parameter int STEP_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/thermometer_encoder.sv
// Binary level request to W-bit thermometer code with one-segment-per-step ramping.
// Define THERM_SLEW_EN for the slew-limited ramp; undefined, the target loads in one edge.
module thermometer_encoder
    import therm_pkg::*;
#(
    parameter int K        = 3,
    parameter int W        = 7,
    parameter int STEP_DIV = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [K-1:0] in_code,
    output logic         in_ready,
    output logic [W-1:0] therm,
    output logic [K-1:0] level,
    output logic         busy,
    output logic         done
);

    if (!therm_width_ok(K, W)) begin : g_bad_width
        $error("thermometer_encoder: W must equal 2**K-1");
    end
    if (STEP_DIV < 1) begin : g_bad_div
        $error("thermometer_encoder: STEP_DIV must be at least 1");
    end

    logic accept;

`ifdef THERM_SLEW_EN

    state_t       state;
    logic [K-1:0] target;
    logic [K-1:0] level_step;
    logic [W-1:0] therm_step;
    logic         tick;

    assign in_ready = (state == ST_IDLE) && rst_n;
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && in_ready;

    therm_step_timer #(
        .STEP_DIV(STEP_DIV)
    ) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .enable(busy),
        .tick  (tick)
    );

    always_comb begin
        level_step = level;
        if (state == ST_UP) begin
            level_step = level + 1'b1;
        end else if (state == ST_DOWN) begin
            level_step = level - 1'b1;
        end
        therm_step = W'(therm_expand(32'(level_step)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            level  <= '0;
            target <= '0;
            therm  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target <= in_code;
                        if (in_code == level) begin
                            done <= 1'b1;
                        end else if (in_code > level) begin
                            state <= ST_UP;
                        end else begin
                            state <= ST_DOWN;
                        end
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (tick) begin
                        level <= level_step;
                        therm <= therm_step;
                        // Arrival returns to IDLE on the same edge so a new request can follow at once.
                        if (level_step == target) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`else

    logic [W-1:0] therm_load;

    assign in_ready   = rst_n;
    assign busy       = 1'b0;
    assign accept     = in_valid && in_ready;
    assign therm_load = W'(therm_expand(32'(in_code)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            therm <= '0;
            done  <= 1'b0;
        end else begin
            done <= accept;
            if (accept) begin
                level <= in_code;
                therm <= therm_load;
            end
        end
    end

`endif

endmodule
